// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory access in flight, with byte/half/word lane
// steering, sign/zero extension and alignment rejection.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  Misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    state_t                state_r;
    state_t                state_next_s;
    logic                  mem_we_r;
    logic [DATA_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic [3:0]            mem_be_r;
    logic [1:0]            size_r;
    logic                  uns_r;
    logic [1:0]            off_r;
    logic [DATA_WIDTH-1:0] read_data_r;

    logic                  req_s;
    logic [1:0]            size_s;
    logic                  uns_s;
    logic                  aligned_s;
    logic                  start_s;
    logic                  stall_s;
    logic                  misaligned_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [3:0]            be_s;
    logic [DATA_WIDTH-1:0] load_s;

    // Unused funct3 encodings (011/110/111) fall back to a word access.
    function automatic logic [1:0] decode_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: decode_size = SZ_B;
            3'b001, 3'b101: decode_size = SZ_H;
            default:        decode_size = SZ_W;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        if (off[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            SZ_B:    extract_load = {{(DATA_WIDTH-8){b[7] & ~uns}}, b};
            SZ_H:    extract_load = {{(DATA_WIDTH-16){h[15] & ~uns}}, h};
            default: extract_load = word;
        endcase
    endfunction

    assign req_s   = MemRead | MemWrite;
    assign size_s  = decode_size(funct3);
    assign uns_s   = funct3[2];
    assign load_s  = extract_load(mem_rdata, off_r, size_r, uns_r);

    // Alignment check and store lane steering for the incoming request.
    always_comb begin
        aligned_s = 1'b1;
        wdata_s   = {DATA_WIDTH{1'b0}};
        be_s      = 4'b0000;
        case (size_s)
            SZ_B: begin
                aligned_s = 1'b1;
                wdata_s   = {(DATA_WIDTH/8){WriteData[7:0]}};
                be_s      = 4'b0001 << ALUResult[1:0];
            end
            SZ_H: begin
                aligned_s = ~ALUResult[0];
                wdata_s   = {(DATA_WIDTH/16){WriteData[15:0]}};
                be_s      = ALUResult[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                aligned_s = (ALUResult[1:0] == 2'b00);
                wdata_s   = WriteData;
                be_s      = 4'b1111;
            end
        endcase
    end

    // Next-state logic plus the combinational Stall/Misaligned handshake.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        stall_s      = 1'b0;
        misaligned_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && aligned_s) begin
                    state_next_s = BUSY;
                    start_s      = 1'b1;
                    stall_s      = 1'b1;
                end else if (req_s) begin
                    state_next_s = IDLE;
                    misaligned_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (mem_ready) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register, request capture and load result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {DATA_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            mem_be_r    <= 4'b0000;
            size_r      <= SZ_B;
            uns_r       <= 1'b0;
            off_r       <= 2'b00;
            read_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (start_s) begin
                mem_we_r    <= MemWrite;
                mem_addr_r  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                mem_wdata_r <= MemWrite ? wdata_s : {DATA_WIDTH{1'b0}};
                mem_be_r    <= MemWrite ? be_s : 4'b0000;
                size_r      <= size_s;
                uns_r       <= uns_s;
                off_r       <= ALUResult[1:0];
            end
            if ((state_r == BUSY) && mem_ready && !mem_we_r) begin
                read_data_r <= load_s;
            end
        end
    end

    assign mem_req    = (state_r == BUSY);
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_be     = mem_be_r;
    assign ReadData   = read_data_r;
    assign Stall      = stall_s;
    assign Misaligned = misaligned_s;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with hand-computed results
// plus hand-written multi-cycle sequences (stall hold, reset in BUSY).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult, WriteData, mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, ReadData;
    logic [3:0]  mem_be;
    logic        Stall, Misaligned;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .ReadData(ReadData), .Stall(Stall),
        .Misaligned(Misaligned)
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        funct3    = 3'b000;
        ALUResult = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        ALUResult = addr;
        WriteData = wd;
    endtask

    // Starts and finishes on a negedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        drive(v.rd, v.wr, v.f3, v.addr, v.wdata);
        #1;
        if (v.mis) begin
            check({t, ".misaligned"}, {31'b0, Misaligned}, 32'd1);
            check({t, ".stall_mis"}, {31'b0, Stall}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            check({t, ".no_req"}, {31'b0, mem_req}, 32'd0);
            idle_inputs();
            #1;
            check({t, ".mis_clear"}, {31'b0, Misaligned}, 32'd0);
            check({t, ".rd_hold"}, ReadData, v.e_rd);
        end else begin
            check({t, ".stall_req"}, {31'b0, Stall}, 32'd1);
            check({t, ".mis0"}, {31'b0, Misaligned}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            check({t, ".req"}, {31'b0, mem_req}, 32'd1);
            check({t, ".we"}, {31'b0, mem_we}, {31'b0, v.wr});
            check({t, ".addr"}, mem_addr, v.e_addr);
            check({t, ".wdata"}, mem_wdata, v.e_wdata);
            check({t, ".be"}, {28'b0, mem_be}, {28'b0, v.e_be});
            check({t, ".stall_busy"}, {31'b0, Stall}, 32'd1);
            mem_ready = 1'b1;
            mem_rdata = v.rdata;
            @(posedge clk);
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
            check({t, ".done_req"}, {31'b0, mem_req}, 32'd0);
            check({t, ".done_stall"}, {31'b0, Stall}, 32'd0);
            check({t, ".readdata"}, ReadData, v.e_rd);
            idle_inputs();
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        //          rd    wr    f3      addr          wdata         rdata         mis   e_addr        e_wdata       e_be     e_rd
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,        32'hBEEF_0000, 1'b0, 32'h0000_0200, 32'h0,        4'b0000, 32'h0000_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_00AB, 32'h0,        1'b0, 32'h0000_0010, 32'hABAB_ABAB, 4'b0010, 32'h0000_BEEF};
        vecs[3]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_BEEF};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0046, 32'h0,        32'h8001_7FFF, 1'b0, 32'h0000_0044, 32'h0,        4'b0000, 32'hFFFF_8001};
        vecs[5]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0041, 32'h0,        32'h1234_F056, 1'b0, 32'h0000_0040, 32'h0,        4'b0000, 32'h0000_00F0};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_C0DE, 32'h0,        1'b0, 32'h0000_0020, 32'hC0DE_C0DE, 4'b1100, 32'h0000_00F0};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0030, 32'h1234_5678, 32'h0,        1'b0, 32'h0000_0030, 32'h1234_5678, 4'b1111, 32'h0000_00F0};
        vecs[8]  = '{1'b1, 1'b0, 3'b111, 32'h0000_003C, 32'h0,        32'hCAFE_BABE, 1'b0, 32'h0000_003C, 32'h0,        4'b0000, 32'hCAFE_BABE};
        vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0021, 32'h1111_2222, 32'h0,        1'b1, 32'h0,        32'h0,        4'b0000, 32'hCAFE_BABE};
        vecs[10] = '{1'b1, 1'b1, 3'b000, 32'h0000_0053, 32'h0000_0077, 32'hFFFF_FFFF, 1'b0, 32'h0000_0050, 32'h7777_7777, 4'b1000, 32'hCAFE_BABE};
        vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h0000_0050, 32'h0,        32'h0000_007F, 1'b0, 32'h0000_0050, 32'h0,        4'b0000, 32'h0000_007F};
        vecs[12] = '{1'b1, 1'b0, 3'b101, 32'h0000_0003, 32'h0,        32'h0,        1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_007F};
        vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h0080_0000, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80};
        vecs[14] = '{1'b0, 1'b1, 3'b011, 32'h0000_0004, 32'hA5A5_0F0F, 32'h0,        1'b0, 32'h0000_0004, 32'hA5A5_0F0F, 4'b1111, 32'hFFFF_FF80};

        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.req", {31'b0, mem_req}, 32'd0);
        check("rst.we", {31'b0, mem_we}, 32'd0);
        check("rst.addr", mem_addr, 32'h0);
        check("rst.wdata", mem_wdata, 32'h0);
        check("rst.be", {28'b0, mem_be}, 32'h0);
        check("rst.readdata", ReadData, 32'h0);
        check("rst.stall", {31'b0, Stall}, 32'd0);
        check("rst.mis", {31'b0, Misaligned}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        // mem_ready while IDLE must not start anything.
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        check("idle_ready.req", {31'b0, mem_req}, 32'd0);
        check("idle_ready.rd", ReadData, 32'hFFFF_FF80);

        // Store held off by memory for 5 cycles; request must stay stable.
        drive(1'b0, 1'b1, 3'b010, 32'h0000_0060, 32'h1122_3344);
        #1;
        check("sw_wait.stall0", {31'b0, Stall}, 32'd1);
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("sw_wait.req%0d", c), {31'b0, mem_req}, 32'd1);
            check($sformatf("sw_wait.addr%0d", c), mem_addr, 32'h0000_0060);
            check($sformatf("sw_wait.wdata%0d", c), mem_wdata, 32'h1122_3344);
            check($sformatf("sw_wait.stall%0d", c), {31'b0, Stall}, 32'd1);
            if (c == 4) mem_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        check("sw_wait.done_req", {31'b0, mem_req}, 32'd0);
        check("sw_wait.done_stall", {31'b0, Stall}, 32'd0);
        check("sw_wait.rd_kept", ReadData, 32'hFFFF_FF80);

        // A new request presented during DONE is ignored; seen again in IDLE.
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0);
        #1;
        check("done_req.stall", {31'b0, Stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done_req.no_busy", {31'b0, mem_req}, 32'd0);
        check("done_req.idle_stall", {31'b0, Stall}, 32'd1);
        idle_inputs();
        #1;
        check("done_req.released", {31'b0, Stall}, 32'd0);

        // Reset while BUSY abandons the access.
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0090, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_busy.req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy.req0", {31'b0, mem_req}, 32'd0);
        check("rst_busy.rd0", ReadData, 32'h0);
        check("rst_busy.addr0", mem_addr, 32'h0);
        check("rst_busy.stall0", {31'b0, Stall}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        check("rst_busy.no_done", ReadData, 32'h0);
        check("rst_busy.stay_idle", {31'b0, mem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of data and address paths.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 MemRead  in  1  load request from control unit.
REQ-005 MemWrite  in  1  store request from control unit.
REQ-006 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResult  in  DATA_WIDTH  byte address from execute stage.
REQ-008 WriteData  in  DATA_WIDTH  store data from register file (low bits significant).
REQ-009 mem_rdata  in  DATA_WIDTH  word read from data memory.
REQ-010 mem_ready  in  1  data memory completes the current request.
REQ-011 mem_req  out  1  request valid to data memory.
REQ-012 mem_we  out  1  request is a store.
REQ-013 mem_addr  out  DATA_WIDTH  word-aligned address (bits [1:0] = 00).
REQ-014 mem_wdata  out  DATA_WIDTH  lane-replicated store data.
REQ-015 mem_be  out  4  byte enables for the store.
REQ-016 ReadData  out  DATA_WIDTH  aligned, extended load result to result mux.
REQ-017 Stall  out  1  holds upstream pipeline while an access is outstanding.
REQ-018 Misaligned  out  1  one-cycle flag: access rejected for alignment.

Function
REQ-019 FSM states IDLE, BUSY, DONE; one access in flight maximum.
REQ-020 IDLE->BUSY when (MemRead|MemWrite) and address aligned; mem_addr, mem_we, mem_wdata, mem_be, funct3, ALUResult[1:0] registered on that edge.
REQ-021 BUSY: mem_req=1, request outputs held constant until mem_ready sampled high.
REQ-022 BUSY->DONE on mem_ready=1; for loads, ReadData registered from mem_rdata on that edge.
REQ-023 DONE->IDLE unconditionally after one cycle; requests present during DONE are ignored (they belong to the completing instruction).
REQ-024 Stall = 1 in BUSY, and in IDLE when an aligned request is present; Stall = 0 in DONE.
REQ-025 Minimum latency: request cycle N, mem_req from N+1, mem_ready at N+1 gives DONE at N+2.
REQ-026 MemWrite and MemRead both high: treated as store; read ignored.
REQ-027 funct3 011/110/111: treated as word access (010).
REQ-028 Alignment: H/HU/SH needs addr[0]=0; W needs addr[1:0]=00; B always aligned.
REQ-029 Misaligned request in IDLE: no transition, mem_req stays 0, Stall=0, Misaligned=1 for that cycle, ReadData unchanged.
REQ-030 Store byte: mem_be = 0001 << addr[1:0], mem_wdata = WriteData[7:0] replicated x4.
REQ-031 Store half: mem_be = 0011 (addr[1]=0) or 1100 (addr[1]=1), mem_wdata = WriteData[15:0] replicated x2.
REQ-032 Store word: mem_be = 1111, mem_wdata = WriteData.
REQ-033 Loads: mem_be = 0000, mem_we = 0.
REQ-034 Load byte lane = mem_rdata[8*addr[1:0] +: 8]; half lane = mem_rdata[16*addr[1] +: 16].
REQ-035 B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-036 ReadData holds its value from DONE until the next load's DONE; stores do not modify it.
REQ-037 mem_ready while IDLE or DONE is ignored.

Reset
REQ-038 rst=1 at an edge: state IDLE; mem_req, mem_we, Misaligned, Stall-driving state 0; mem_addr, mem_wdata, mem_be, ReadData = 0.
REQ-039 rst during BUSY: request abandoned, mem_req=0 from the following cycle, no DONE generated.

Verification
REQ-040 LB addr 0x0000_0103, mem_rdata 0x80FF_1234, mem_ready 1 cycle later -> mem_addr 0x100, ReadData 0xFFFF_FF80, Stall 1 for 2 cycles.
REQ-041 LHU addr 0x0000_0202, mem_rdata 0xBEEF_0000 -> ReadData 0x0000_BEEF.
REQ-042 SB addr 0x0000_0011, WriteData 0x0000_00AB -> mem_be 0010, mem_wdata 0xABAB_ABAB, mem_we 1.
REQ-043 LW addr 0x0000_0006 -> Misaligned 1 for one cycle, mem_req never 1, Stall 0.
REQ-044 SW with mem_ready held low 5 cycles -> mem_req, mem_addr, mem_wdata stable, Stall 1 throughout; DONE one cycle after mem_ready.
REQ-045 rst asserted in BUSY -> mem_req 0 next cycle, ReadData 0, state IDLE, no Stall release glitch into DONE.
